// File: rtl/alu_sweep_driver.sv
// Sweeps every ALU opcode over one latched operand pair.
// Captures {v,z,f} per opcode into a readable result buffer.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   start, a_in, b_in   sweep request and operands (taken in IDLE)
//   busy, done          status; done is a one-cycle pulse
//   alu_a/b/sel         registered drive to the ALU
//   alu_f/v/z           ALU result and flags
//   rd_addr, rd_data    combinational result-buffer read
//   v_count, z_count    flag tallies of the current/last sweep
module alu_sweep_driver #(
  parameter int W          = 3,
  parameter int FW         = 5,
  parameter int NUM_OPS    = 11,
  parameter int SETTLE_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  a_in,
  input  logic [W-1:0]  b_in,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [3:0]    alu_sel,
  input  logic [FW-1:0] alu_f,
  input  logic          alu_v,
  input  logic          alu_z,
  input  logic [3:0]    rd_addr,
  output logic [FW+1:0] rd_data,
  output logic [3:0]    v_count,
  output logic [3:0]    z_count
);

  localparam int CW =
    (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0] SET_LD = CW'(SETTLE_CYC);
  localparam logic [3:0] LAST = 4'(NUM_OPS - 1);
  localparam logic [3:0] NOPS = 4'(NUM_OPS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [3:0]    sel_q, sel_d;
  logic [3:0]    vc_q, vc_d;
  logic [3:0]    zc_q, zc_d;
  logic          cap;

  logic [FW+1:0] res_q [NUM_OPS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      vc_q    <= '0;
      zc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      vc_q    <= vc_d;
      zc_q    <= zc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    vc_d    = vc_q;
    zc_d    = zc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          sel_d   = '0;
          vc_d    = '0;
          zc_d    = '0;
          cnt_d   = SET_LD;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // cnt holds the remaining settle cycles incl. this one
        if (cnt_q == CW'(1)) state_d = S_CAPTURE;
        else cnt_d = cnt_q - CW'(1);
      end
      S_CAPTURE: begin
        vc_d = vc_q + {3'b000, alu_v};
        zc_d = zc_q + {3'b000, alu_z};
        if (sel_q == LAST) begin
          state_d = S_DONE;
        end else begin
          sel_d   = sel_q + 4'd1;
          cnt_d   = SET_LD;
          state_d = S_SETTLE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
    cap  = (state_q == S_CAPTURE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_OPS; i++)
        res_q[i] <= '0;
    end else if (cap) begin
      res_q[sel_q] <= {alu_v, alu_z, alu_f};
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_addr < NOPS) rd_data = res_q[rd_addr];
  end

  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_sel = sel_q;
  assign v_count = vc_q;
  assign z_count = zc_q;

endmodule
